// File: rtl/instruction_fetch_queue.sv
// ---------------------------------------------------------------------------
// instruction_fetch_queue
//
// Instruction Fetch stage prefetch queue. Generates word-aligned fetch
// addresses for a combinational instruction memory, captures the returned
// words together with their fetch address, and buffers them in a DEPTH-entry
// circular queue drained by decode through a valid/ready handshake.
// Branch redirects flush the queue and restart fetching at the target.
//
// Optional feature macro: FETCH_BRANCH_BYPASS_EN
//   defined   : the redirect target is presented to memory in the branch
//               cycle and its word is queued at that same edge (1-edge
//               redirect penalty).
//   undefined : imem_address is purely registered (2-edge redirect penalty).
//
// Ports:
//   clk              in   clock, all state updates on rising edge
//   rst_n            in   synchronous active-low reset
//   imem_address     out  byte address presented to instruction memory
//   imem_instruction in   memory read data for imem_address (same cycle)
//   branch_taken     in   redirect request from execute
//   branch_address   in   redirect target (bits [1:0] ignored)
//   out_valid        out  head entry valid
//   out_instruction  out  head instruction (0 when empty)
//   out_pc           out  head instruction byte address + 4 (0 when empty)
//   out_ready        in   decode accepts head this cycle
// ---------------------------------------------------------------------------
module instruction_fetch_queue #(
    parameter int unsigned                DEPTH       = 4,
    parameter int unsigned                WORD_LEN    = 32,
    parameter int unsigned                ADDRESS_LEN = 32,
    parameter logic [ADDRESS_LEN-1:0]     RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ADDRESS_LEN-1:0] imem_address,
    input  logic [WORD_LEN-1:0]    imem_instruction,
    input  logic                   branch_taken,
    input  logic [ADDRESS_LEN-1:0] branch_address,
    output logic                   out_valid,
    output logic [WORD_LEN-1:0]    out_instruction,
    output logic [ADDRESS_LEN-1:0] out_pc,
    input  logic                   out_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]       DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [ADDRESS_LEN-1:0] WORD_STEP = ADDRESS_LEN'(4);
    localparam logic [ADDRESS_LEN-1:0] RESET_PC_ALIGNED =
        {RESET_PC[ADDRESS_LEN-1:2], 2'b00};

    // Queue storage (no reset needed: entries are only read when counted).
    logic [WORD_LEN-1:0]    instr_q [DEPTH];
    logic [ADDRESS_LEN-1:0] addr_q  [DEPTH];

    logic [ADDRESS_LEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   wr_en;
    logic [PTR_W-1:0]       wr_idx;
    logic [ADDRESS_LEN-1:0] wr_addr;

    logic                   empty;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic [ADDRESS_LEN-1:0] branch_target;

    // Low address bits of the redirect target carry no information.
    logic unused_branch_low;
    assign unused_branch_low = ^branch_address[1:0];

    assign branch_target = {branch_address[ADDRESS_LEN-1:2], 2'b00};

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);
    assign pop   = !empty && out_ready;
    assign push  = !full || pop;

`ifdef FETCH_BRANCH_BYPASS_EN
    assign imem_address = branch_taken ? branch_target : fetch_pc_q;
`else
    assign imem_address = fetch_pc_q;
`endif

    assign out_valid       = !empty;
    assign out_instruction = empty ? '0 : instr_q[rd_ptr_q];
    assign out_pc          = empty ? '0 : (addr_q[rd_ptr_q] + WORD_STEP);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        wr_en      = 1'b0;
        wr_idx     = wr_ptr_q;
        wr_addr    = fetch_pc_q;

        if (branch_taken) begin
            // Redirect flushes everything, including any pop this cycle.
            rd_ptr_d = '0;
`ifdef FETCH_BRANCH_BYPASS_EN
            // Target word is already on imem_instruction: seed entry 0.
            wr_en      = 1'b1;
            wr_idx     = '0;
            wr_addr    = branch_target;
            wr_ptr_d   = PTR_W'(1);
            count_d    = CNT_W'(1);
            fetch_pc_d = branch_target + WORD_STEP;
`else
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = branch_target;
`endif
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                wr_en      = 1'b1;
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + WORD_STEP;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC_ALIGNED;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            instr_q[wr_idx] <= imem_instruction;
            addr_q[wr_idx]  <= wr_addr;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_queue
//
// Directed bench for instruction_fetch_queue. Instruction memory model:
// word at byte address A is (A >> 2) + 1, so word[i] = i + 1.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_ready;

    int total;
    int bad;

    instruction_fetch_queue #(
        .DEPTH       (4),
        .WORD_LEN    (32),
        .ADDRESS_LEN (32),
        .RESET_PC    (32'h0)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .branch_taken     (branch_taken),
        .branch_address   (branch_address),
        .out_valid        (out_valid),
        .out_instruction  (out_instruction),
        .out_pc           (out_pc),
        .out_ready        (out_ready)
    );

    assign imem_instruction = (imem_address >> 2) + 32'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_head(input string tag, input logic [31:0] instr, input logic [31:0] pc);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".instr"}, out_instruction, instr);
        check({tag, ".pc"}, out_pc, pc);
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".instr"}, out_instruction, 32'd0);
        check({tag, ".pc"}, out_pc, 32'd0);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        branch_taken   = 1'b0;
        branch_address = 32'h0;
        out_ready      = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst.imem", imem_address, 32'h0);
        check_empty("rst");

        // Streaming with out_ready high: 1,2,3,4 with pc 4,8,12,16
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_head("stream", 32'(k), 32'(4 * k));
            check("stream.imem", imem_address, 32'(4 * k));
        end

        // Decode stall for 10 cycles after reset
        rst_n     = 1'b0;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("stall.imem", imem_address, 32'd16);
        check_head("stall", 32'd1, 32'd4);
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_head("stall_rel", 32'(k + 1), 32'(4 * (k + 1)));
        end

        // Branch to 0x103 with 3 entries queued and a pop asserted
        rst_n     = 1'b0;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        branch_taken   = 1'b1;
        branch_address = 32'h103;
        out_ready      = 1'b1;
        tick();
        check("br.imem", imem_address, 32'h100);
`ifdef FETCH_BRANCH_BYPASS_EN
        check_head("br.e0", 32'd65, 32'h104);
`else
        check_empty("br.e0");
`endif
        branch_taken = 1'b0;
        out_ready    = 1'b0;
        tick();
        check_head("br.e1", 32'd65, 32'h104);

        // Back-to-back branches: 0x40 then 0x80
        branch_taken   = 1'b1;
        branch_address = 32'h40;
        tick();
        branch_address = 32'h80;
        tick();
`ifdef FETCH_BRANCH_BYPASS_EN
        check_head("b2b.e0", 32'd33, 32'h84);
`else
        check_empty("b2b.e0");
`endif
        branch_taken = 1'b0;
        tick();
        check_head("b2b.e1", 32'd33, 32'h84);
        out_ready = 1'b1;
        tick();
        check_head("b2b.e2", 32'd34, 32'h88);
        tick();
        check_head("b2b.e3", 32'd35, 32'h8C);

        // Address wrap with a full queue and continuous draining
        branch_taken   = 1'b1;
        branch_address = 32'hFFFF_FFF0;
        out_ready      = 1'b0;
        tick();
        branch_taken = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("wrap.imem0", imem_address, 32'h0);
        check_head("wrap.full", 32'h3FFF_FFFD, 32'hFFFF_FFF4);
        out_ready = 1'b1;
        tick();
        check_head("wrap.1", 32'h3FFF_FFFE, 32'hFFFF_FFF8);
        tick();
        check_head("wrap.2", 32'h3FFF_FFFF, 32'hFFFF_FFFC);
        tick();
        check_head("wrap.3", 32'h4000_0000, 32'h0);
        tick();
        check_head("wrap.4", 32'd1, 32'd4);
        tick();
        check_head("wrap.5", 32'd2, 32'd8);
        check("wrap.imem5", imem_address, 32'd20);

        // One-cycle reset mid-stream with a full queue
        rst_n = 1'b0;
        tick();
        check("mrst.imem", imem_address, 32'h0);
        check_empty("mrst");
        rst_n = 1'b1;
        tick();
        check_head("mrst.e1", 32'd1, 32'd4);
        tick();
        check_head("mrst.e2", 32'd2, 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
